imem_port_arbiter: RTL and testbench

//  Shares one synchronous single-port 2048x32 word memory between two requesters:

---
 rtl/riscv_mem_pkg.sv | 15 +
 rtl/arb_stats.sv | 28 ++
 rtl/imem_port_arbiter.sv | 90 +++++++++
 tb/tb_imem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
// Sizes one 2048x32 word memory and encodes where the next read data goes.
package riscv_mem_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 32;

   typedef enum logic [1:0] {
      ROUTE_NONE = 2'd0,
      ROUTE_IF   = 2'd1,
      ROUTE_DM   = 2'd2
   } route_e;

endpackage

// File: rtl/arb_stats.sv
// Grant and starvation event counters for the memory port arbiter.
// Built only when ARB_STATS_EN is defined; all counters wrap naturally.
module arb_stats
   import riscv_mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             if_gnt,
   input  logic             dm_gnt,
   input  logic             forced,
   output logic [CNT_W-1:0] if_grant_cnt,
   output logic [CNT_W-1:0] dm_grant_cnt,
   output logic [CNT_W-1:0] starve_evt_cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         if_grant_cnt   <= '0;
         dm_grant_cnt   <= '0;
         starve_evt_cnt <= '0;
      end else begin
         if (if_gnt) if_grant_cnt <= if_grant_cnt + 1'b1;
         if (dm_gnt) dm_grant_cnt <= dm_grant_cnt + 1'b1;
         if (forced) starve_evt_cnt <= starve_evt_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port word memory between fetch (IF) and load/store (DM).
// Define ARB_STATS_EN to add grant/starvation counter outputs.
module imem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  if_grant_cnt,
   output logic [CNT_W-1:0]  dm_grant_cnt,
   output logic [CNT_W-1:0]  starve_evt_cnt
`else
   input  logic [DATA_W-1:0] mem_rdata
`endif
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;
   route_e     route;
   logic       forced;

   // DM normally wins; IF takes the contest once it has lost SMAX in a row
   always_comb begin
      forced = if_req & dm_req & (starve_cnt == SMAX);
      if_gnt = if_req & (~dm_req | forced);
      dm_gnt = dm_req & ~if_gnt;
   end

   assign mem_en    = if_gnt | dm_gnt;
   assign mem_we    = dm_gnt & dm_we;
   assign mem_addr  = if_gnt ? if_addr : dm_addr;
   assign mem_wdata = dm_gnt ? dm_wdata : '0;

   assign if_rvalid = (route == ROUTE_IF);
   assign dm_rvalid = (route == ROUTE_DM);
   assign if_rdata  = mem_rdata;
   assign dm_rdata  = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         route      <= ROUTE_NONE;
      end else begin
         if (if_gnt)
            starve_cnt <= '0;
         else if (if_req && starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 1'b1;

         unique case (1'b1)
            if_gnt:           route <= ROUTE_IF;
            dm_gnt && !dm_we: route <= ROUTE_DM;
            default:          route <= ROUTE_NONE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   arb_stats u_stats (
      .clk            (clk),
      .reset          (reset),
      .if_gnt         (if_gnt),
      .dm_gnt         (dm_gnt),
      .forced         (forced),
      .if_grant_cnt   (if_grant_cnt),
      .dm_grant_cnt   (dm_grant_cnt),
      .starve_evt_cnt (starve_evt_cnt)
   );
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomised and directed bench for imem_port_arbiter with an attached
// synchronous memory and a rule-level reference model.
module tb_imem_port_arbiter;
   import riscv_mem_pkg::*;

   localparam int SM = 3;

   logic              clk = 0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req, dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt, dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_STATS_EN
   logic [31:0] if_grant_cnt, dm_grant_cnt, starve_evt_cnt;
`endif

   imem_port_arbiter #(.STARVE_MAX(SM)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
`ifdef ARB_STATS_EN
      .mem_rdata      (mem_rdata),
      .if_grant_cnt   (if_grant_cnt),
      .dm_grant_cnt   (dm_grant_cnt),
      .starve_evt_cnt (starve_evt_cnt)
`else
      .mem_rdata (mem_rdata)
`endif
   );

   always #5 clk = ~clk;

   // Memory array under the arbiter
   logic [DATA_W-1:0] mem [2048];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [DATA_W-1:0] ref_mem [2048];
   int          losses;
   bit          e_ifg, e_dmg, e_forced;
   bit          p_if, p_dm;
   logic [31:0] p_data;
   int          n_if, n_dm, n_st;

   task automatic predict();
      #1;
      e_forced = if_req && dm_req && (losses >= SM);
      e_ifg    = if_req && (!dm_req || losses >= SM);
      e_dmg    = dm_req && !e_ifg;
   endtask

   task automatic tick();
      p_if = 0;
      p_dm = 0;
      if (e_ifg) begin
         p_if   = 1;
         p_data = ref_mem[if_addr];
      end else if (e_dmg) begin
         if (dm_we) ref_mem[dm_addr] = dm_wdata;
         else begin
            p_dm   = 1;
            p_data = ref_mem[dm_addr];
         end
      end
      if (e_ifg) losses = 0;
      else if (if_req) losses = (losses + 1 > SM) ? SM : losses + 1;
      n_if += int'(e_ifg);
      n_dm += int'(e_dmg);
      n_st += int'(e_forced);
      if (reset) begin
         losses = 0;
         p_if = 0;
         p_dm = 0;
         n_if = 0;
         n_dm = 0;
         n_st = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; if_req = 0; if_addr = '0;
      dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      predict();
      tick();
      tick();
      reset = 0;
      predict();
      checks++;
      if ({if_rvalid, dm_rvalid, if_gnt, dm_gnt, mem_en} !== 5'b0) begin
         failures++;
         $display("FAIL reset: rv=%b%b gnt=%b%b en=%b want 0",
                  if_rvalid, dm_rvalid, if_gnt, dm_gnt, mem_en);
      end
   endtask

   task automatic test_if_only();
      idle();
      for (int a = 0; a < 5; a++) begin
         if_req = 1;
         if_addr = ADDR_W'(a);
         predict();
         checks++;
         if ({if_gnt, dm_gnt, mem_en, mem_we, mem_addr} !==
             {2'b10, 2'b10, ADDR_W'(a)}) begin
            failures++;
            $display("FAIL if_only_gnt a=%0d: gnt=%b%b en=%b we=%b addr=%0d",
                     a, if_gnt, dm_gnt, mem_en, mem_we, mem_addr);
         end
         tick();
         checks++;
         if (!if_rvalid || dm_rvalid || if_rdata !== 32'(a + 1)) begin
            failures++;
            $display("FAIL if_only_rd a=%0d: rv=%b%b data=%h want %h",
                     a, if_rvalid, dm_rvalid, if_rdata, 32'(a + 1));
         end
      end
      idle();
      predict();
      tick();
   endtask

   task automatic test_dm_write_read();
      idle();
      dm_req = 1; dm_we = 1; dm_addr = 11'd64; dm_wdata = 32'hDEADBEEF;
      predict();
      checks++;
      if ({dm_gnt, mem_we, mem_addr, mem_wdata} !==
          {2'b11, 11'd64, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL dm_wr_gnt: gnt=%b we=%b addr=%0d wd=%h",
                  dm_gnt, mem_we, mem_addr, mem_wdata);
      end
      tick();
      checks++;
      if (dm_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL dm_wr_rvalid: got %b want 0", dm_rvalid);
      end
      dm_we = 0; dm_wdata = '0;
      predict();
      tick();
      checks++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL dm_rd: rv=%b data=%h want 1/deadbeef",
                  dm_rvalid, dm_rdata);
      end
      idle();
      predict();
      tick();
   endtask

   task automatic test_contention();
      idle();
      reset = 1;
      predict();
      tick();
      reset = 0;
      for (int k = 0; k < 8; k++) begin
         if_req = 1; if_addr = 11'(100 + k);
         dm_req = 1; dm_we = 0; dm_addr = 11'(200 + k);
         predict();
         checks++;
         if ({if_gnt, dm_gnt} !== {k % 4 == 3, k % 4 != 3}) begin
            failures++;
            $display("FAIL contention k=%0d: gnt=%b%b want %b%b",
                     k, if_gnt, dm_gnt, k % 4 == 3, k % 4 != 3);
         end
         tick();
         checks++;
         if ({if_rvalid, dm_rvalid} !== {p_if, p_dm} ||
             if_rdata !== p_data) begin
            failures++;
            $display("FAIL contention_rd k=%0d: rv=%b%b data=%h want %b%b %h",
                     k, if_rvalid, dm_rvalid, if_rdata, p_if, p_dm, p_data);
         end
      end
`ifdef ARB_STATS_EN
      checks++;
      if ({if_grant_cnt, dm_grant_cnt, starve_evt_cnt} !==
          {32'd2, 32'd6, 32'd2}) begin
         failures++;
         $display("FAIL stats: if=%0d dm=%0d st=%0d want 2 6 2",
                  if_grant_cnt, dm_grant_cnt, starve_evt_cnt);
      end
`endif
      idle();
      predict();
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      for (int k = 0; k < 2; k++) begin
         if_req = 1; dm_req = 1; if_addr = 11'd20; dm_addr = 11'd7;
         predict();
         tick();
      end
      dm_req = 0;
      reset = 1;
      predict();
      checks++;
      if (if_gnt !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_gnt: got %b want 1", if_gnt);
      end
      tick();
      reset = 0;
      checks++;
      if (if_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_rvalid: got %b want 0", if_rvalid);
      end
      dm_req = 1;
      for (int k = 0; k < 4; k++) begin
         predict();
         checks++;
         if ({if_gnt, dm_gnt} !== {k == 3, k != 3}) begin
            failures++;
            $display("FAIL reset_mid_cnt k=%0d: gnt=%b%b", k, if_gnt, dm_gnt);
         end
         tick();
      end
      idle();
      predict();
      tick();
   endtask

   task automatic test_interleave();
      idle();
      if_req = 1; if_addr = 11'd21;
      predict();
      tick();
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[21]) begin
         failures++;
         $display("FAIL interleave_if: rv=%b data=%h want 1 %h",
                  if_rvalid, if_rdata, ref_mem[21]);
      end
      if_req = 0;
      dm_req = 1; dm_we = 1; dm_addr = 11'd5; dm_wdata = 32'h5555AAAA;
      predict();
      checks++;
      if ({dm_gnt, mem_we} !== 2'b11) begin
         failures++;
         $display("FAIL interleave_wr: gnt=%b we=%b", dm_gnt, mem_we);
      end
      tick();
      checks++;
      if ({if_rvalid, dm_rvalid} !== 2'b00) begin
         failures++;
         $display("FAIL interleave_rv: rv=%b%b want 00", if_rvalid, dm_rvalid);
      end
      idle();
      predict();
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         reset    = ($urandom_range(0, 49) == 0);
         if_req   = ($urandom_range(0, 3) != 0);
         if_addr  = ADDR_W'($urandom_range(0, 31));
         dm_req   = ($urandom_range(0, 2) != 0);
         dm_we    = $urandom_range(0, 1);
         dm_addr  = ADDR_W'($urandom_range(0, 31));
         dm_wdata = $urandom;
         predict();
         checks++;
         if ({if_gnt, dm_gnt, mem_en, mem_we} !==
             {e_ifg, e_dmg, e_ifg | e_dmg, e_dmg & dm_we} ||
             (mem_en && mem_addr !== (e_ifg ? if_addr : dm_addr)) ||
             (mem_we && mem_wdata !== dm_wdata)) begin
            failures++;
            $display("FAIL rand_gnt k=%0d: gnt=%b%b en=%b we=%b addr=%0d want %b%b",
                     k, if_gnt, dm_gnt, mem_en, mem_we, mem_addr, e_ifg, e_dmg);
         end
         tick();
         checks++;
         if ({if_rvalid, dm_rvalid} !== {p_if, p_dm} ||
             (p_if && if_rdata !== p_data) ||
             (p_dm && dm_rdata !== p_data)) begin
            failures++;
            $display("FAIL rand_rd k=%0d: rv=%b%b if=%h dm=%h want %b%b %h",
                     k, if_rvalid, dm_rvalid, if_rdata, dm_rdata,
                     p_if, p_dm, p_data);
         end
      end
`ifdef ARB_STATS_EN
      checks++;
      if (if_grant_cnt !== 32'(n_if) || dm_grant_cnt !== 32'(n_dm) ||
          starve_evt_cnt !== 32'(n_st)) begin
         failures++;
         $display("FAIL rand_stats: %0d %0d %0d want %0d %0d %0d",
                  if_grant_cnt, dm_grant_cnt, starve_evt_cnt, n_if, n_dm, n_st);
      end
`endif
      idle();
      predict();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         mem[i] = 32'(i + 1);
         ref_mem[i] = 32'(i + 1);
      end
      mem_rdata = '0;
      losses = 0;
      n_if = 0; n_dm = 0; n_st = 0;
      p_if = 0; p_dm = 0; p_data = '0;
      idle();
      @(posedge clk);
      #1;
      test_reset();
      test_if_only();
      test_dm_write_read();
      test_contention();
      test_reset_mid();
      test_interleave();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
